// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
//   DIV_WIDTH    : operand/result width (only 32 is supported; also the step count)
//   LAST_STEP    : index of the final restoring step
//   OVF_DIVIDEND : most negative dividend, the only one that can overflow (with divisor -1)
//   div_state_e  : controller states
//   abs_val      : two's complement magnitude; 0x80000000 maps to unsigned 2^31
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned CNT_W     = 5;

  localparam logic [CNT_W-1:0]     LAST_STEP    = 5'd31;
  localparam logic [DIV_WIDTH-1:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + DIV_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/subtractor_cla_32.sv
// 32-bit subtractor: diff = a - b, computed as a + ~b + 1 over four 8-bit
// carry-lookahead slices whose group carries are chained.
// Ports:
//   a      : minuend
//   b      : subtrahend
//   diff   : a - b (modulo 2^32)
//   borrow : 1 when a < b (unsigned)
module subtractor_cla_32
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic [DIV_WIDTH-1:0] diff,
  output logic                 borrow
);

  localparam int unsigned SliceW = 8;
  localparam int unsigned NumSlices = DIV_WIDTH / SliceW;

  logic [DIV_WIDTH-1:0] b_inv;
  logic [DIV_WIDTH-1:0] gen;
  logic [DIV_WIDTH-1:0] prop;
  logic [DIV_WIDTH-1:0] carry;
  logic [NumSlices:0]   slice_c;
  logic                 c;

  assign b_inv = ~b;
  assign gen   = a & b_inv;
  assign prop  = a ^ b_inv;

  // Each bit's carry is the prefix of its slice's generate/propagate terms
  // off the slice carry-in; synthesis flattens this into lookahead logic.
  always_comb begin
    carry      = '0;
    slice_c    = '0;
    c          = 1'b0;
    slice_c[0] = 1'b1;
    for (int s = 0; s < NumSlices; s++) begin
      for (int i = 0; i < SliceW; i++) begin
        c = slice_c[s];
        for (int j = 0; j < i; j++) begin
          c = gen[s*SliceW+j] | (prop[s*SliceW+j] & c);
        end
        carry[s*SliceW+i] = c;
      end
      slice_c[s+1] = gen[s*SliceW+SliceW-1] | (prop[s*SliceW+SliceW-1] & carry[s*SliceW+SliceW-1]);
    end
  end

  assign diff   = prop ^ carry;
  assign borrow = ~slice_c[NumSlices];

endmodule

// File: rtl/div_iterative_32.sv
// Multi-cycle signed 32-bit restoring divider. One subtract-and-shift step per
// clock on magnitudes, then a sign fix-up through the same subtractor.
// Optional feature macro: DIV_REMAINDER_EN adds data_remainder and one extra
// fix-up cycle to negate the remainder.
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   ctrl_div        : start pulse; operands sampled on the same edge (restarts if busy)
//   data_operandA/B : dividend / divisor, two's complement
//   data_result     : quotient, truncated toward zero
//   data_exception  : divide-by-zero or overflow
//   data_resultRDY  : one-cycle result strobe
//   data_busy       : operation in progress
//   data_remainder  : remainder with the dividend's sign (DIV_REMAINDER_EN only)
module div_iterative_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_busy
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  // rem < divisor <= 2^31, so the partial remainder never needs bit 31.
  logic [WIDTH-2:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
`ifdef DIV_REMAINDER_EN
  logic             a_sign_q, a_sign_d;
  logic             fix_rem_q, fix_rem_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
`endif

  logic [WIDTH-1:0] sub_a, sub_b, sub_diff;
  logic             sub_borrow;

  subtractor_cla_32 u_sub (
    .a      (sub_a),
    .b      (sub_b),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // Shared subtractor: trial subtract while BUSY, negate (0 - x) in FIX.
  always_comb begin
    sub_a = {rem_q, quo_q[WIDTH-1]};
    sub_b = dvsr_q;
    if (state_q == FIX) begin
      sub_a = '0;
`ifdef DIV_REMAINDER_EN
      sub_b = fix_rem_q ? {1'b0, rem_q} : quo_q;
`else
      sub_b = quo_q;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef DIV_REMAINDER_EN
    a_sign_d  = a_sign_q;
    fix_rem_d = fix_rem_q;
    rem_out_d = rem_out_q;
`endif
    if (ctrl_div) begin
      // Start (or abort-and-restart) from any state.
      rem_d   = '0;
      quo_d   = abs_val(data_operandA);
      dvsr_d  = abs_val(data_operandB);
      sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      ovf_d   = (data_operandA == OVF_DIVIDEND) && (data_operandB == '1);
      count_d = '0;
      exc_d   = 1'b0;
`ifdef DIV_REMAINDER_EN
      a_sign_d  = data_operandA[WIDTH-1];
      fix_rem_d = 1'b0;
`endif
      if (data_operandB == '0) begin
        result_d = '0;
        exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
        rem_out_d = '0;
`endif
        state_d  = DONE;
      end else begin
        state_d = BUSY;
      end
    end else begin
      case (state_q)
        BUSY: begin
          rem_d   = sub_borrow ? sub_a[WIDTH-2:0] : sub_diff[WIDTH-2:0];
          quo_d   = {quo_q[WIDTH-2:0], ~sub_borrow};
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_STEP) begin
            state_d = FIX;
          end
        end
        FIX: begin
`ifdef DIV_REMAINDER_EN
          if (!fix_rem_q) begin
            result_d  = sign_q ? sub_diff : quo_q;
            fix_rem_d = 1'b1;
          end else begin
            rem_out_d = a_sign_q ? sub_diff : {1'b0, rem_q};
            exc_d     = ovf_q;
            state_d   = DONE;
          end
`else
          result_d = sign_q ? sub_diff : quo_q;
          exc_d    = ovf_q;
          state_d  = DONE;
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      a_sign_q  <= 1'b0;
      fix_rem_q <= 1'b0;
      rem_out_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef DIV_REMAINDER_EN
      a_sign_q  <= a_sign_d;
      fix_rem_q <= fix_rem_d;
      rem_out_q <= rem_out_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign data_busy      = (state_q == BUSY) || (state_q == FIX);
`ifdef DIV_REMAINDER_EN
  assign data_remainder = rem_out_q;
`endif

endmodule

// File: tb/tb_div_iterative_32.sv
// Scoreboard bench for div_iterative_32: stimulus pushes expected results,
// a negedge monitor pops and compares on every data_resultRDY strobe.
module tb_div_iterative_32;

`ifdef DIV_REMAINDER_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 34;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  div_iterative_32 dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic        exc;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && data_resultRDY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe: unexpected data_resultRDY at cycle %0d, none expected", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", data_result, mon_e.q);
        chk("exception", {31'd0, data_exception}, {31'd0, mon_e.exc});
        chk("strobe_cycle", cyc, mon_e.cyc);
`ifdef DIV_REMAINDER_EN
        chk("remainder", data_remainder, mon_e.r);
`endif
      end
    end
  end

  // Called #1 after a posedge (cycle 0); returns #1 after the next posedge (cycle 1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic exc, input logic [31:0] r, input int lat);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_div      = 1'b1;
    e.q   = q;
    e.exc = exc;
    e.r   = r;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", {31'd0, data_exception}, 32'h0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'h0);
    chk("reset_busy", {31'd0, data_busy}, 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 100 / 7 with busy profile over the whole operation
    issue(32'd100, 32'd7, 32'd14, 1'b0, 32'd2, LAT);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clock);
      chk("busy_profile", {31'd0, data_busy}, {31'd0, (i < LAT)});
      @(posedge clock);
      #1;
    end
    drain();

    issue(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFFE, LAT);
    drain();

    // divide by zero, then a normal op
    issue(32'd5, 32'd0, 32'd0, 1'b1, 32'd0, 1);
    drain();
    issue(32'd9, 32'd3, 32'd3, 1'b0, 32'd0, LAT);
    drain();

    // overflow and most-negative dividend
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd0, LAT);
    drain();
    issue(32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 32'd0, LAT);
    drain();

    issue(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'd1, LAT);
    drain();
    issue(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 32'd0, LAT);
    drain();

    // abort: restart in cycle 10, first op yields no strobe
    issue(32'd1000, 32'd10, 32'd100, 1'b0, 32'd0, LAT);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    sb.delete(sb.size() - 1);
    issue(32'd50, 32'd5, 32'd10, 1'b0, 32'd0, LAT);
    drain();

    // back-to-back: new start in the strobe cycle
    issue(32'd9, 32'd3, 32'd3, 1'b0, 32'd0, LAT);
    repeat (LAT - 1) begin
      @(posedge clock);
      #1;
    end
    issue(32'd20, 32'd4, 32'd5, 1'b0, 32'd0, LAT);
    drain();

    // reset mid-operation in cycle 15
    issue(32'd77, 32'hFFFF_FFFC, 32'hFFFF_FFED, 1'b0, 32'd1, LAT);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_result", data_result, 32'h0);
    chk("midreset_exc", {31'd0, data_exception}, 32'h0);
    chk("midreset_rdy", {31'd0, data_resultRDY}, 32'h0);
    chk("midreset_busy", {31'd0, data_busy}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    issue(32'hFFFF_FFB3, 32'hFFFF_FFFC, 32'd19, 1'b0, 32'hFFFF_FFFF, LAT);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
